lp_arbiter: RTL and testbench
=============================

# lp_arbiter

Four-requester arbiter that shares a single resource using fixed lowest-index-first priority: `req[0]` is highest, the same ordering as the team's low-priority encoder. A grant is held while the owner keeps its request asserted. A hold-limit counter forcibly revokes a grant that runs too long, and the revoked requester is parked out of arbitration until it drops its request. Sits between requesting masters and a shared datapath; `gnt` drives the datapath select.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per ownership. Legal range is 1..255.
- `clk`  in  1: clock. All logic is on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `req`  in  4: request lines, one per requester, level-sensitive.
- `gnt`  out  4: one-hot grant, all zero when idle. Registered.
- `gnt_id`  out  2: index of the current owner. Valid only while `gnt_valid`=1, otherwise 2'b00. Registered.
- `gnt_valid`  out  1: 1 while any grant is active. Registered.
- `timeout`  out  1: one-cycle pulse in the first cycle after a forced revocation. Registered.

## Operation
- **State machine:** two states, IDLE and GRANT. Internal registers:
  - `hold_cnt`: 8 bits, sized for MAX_HOLD ≤ 255.
  - `mask`: 4 bits.
- **Arbitration:**
  - `elig = req & ~mask`.
  - The winner is the lowest set bit of `elig`.
  - Arbitration happens only in IDLE.
- **IDLE:**
  - `elig` nonzero: next state GRANT. Load `gnt` = one-hot(winner), `gnt_id` = winner, `gnt_valid`=1, `hold_cnt`=1.
  - `elig` == 0: stay in IDLE. All grant outputs are 0.
- **GRANT** (owner = `gnt_id`), evaluated each edge in priority order:
  1. `req[owner]`=0: release. Next state IDLE, grant outputs cleared, no timeout, mask unchanged.
  2. Otherwise, `hold_cnt`==MAX_HOLD: revoke. Next state IDLE, grant outputs cleared, `timeout`=1 for one cycle, `mask[owner]` set to 1.
  3. Otherwise: stay in GRANT and increment `hold_cnt`.
- **Mask behaviour:**
  - Each `mask[k]` clears on any edge where `req[k]`=0.
  - When a bit is set and cleared on the same edge, set wins. This case is unreachable in practice, because revocation requires `req[owner]`=1.
  - A masked requester stays parked until it deasserts `req` for at least one cycle.
  - If all requesters are masked, the arbiter idles until one deasserts.
- **Request changes during GRANT:** a higher-priority request arriving mid-grant does not preempt. It wins at the next IDLE arbitration.
- **Reset values:**
  - State IDLE.
  - `gnt`=4'b0000, `gnt_id`=2'b00, `gnt_valid`=0, `timeout`=0.
  - `hold_cnt`=0, `mask`=4'b0000.
- **Reset mid-grant:** the grant is dropped on the reset edge with no timeout pulse, and the mask is cleared.
- **Unknowns:** `req` bits that are X are not a legal input; behaviour is unspecified.

## Timing
- **Request-to-grant latency:** 1 cycle. If `req` is sampled at edge n in IDLE, `gnt` is high from edge n to edge n+1.
- **Release latency:** 1 cycle. If `req[owner]`=0 is sampled at edge m, `gnt` is low after edge m.
- **Turnaround:** every ownership ends with at least one IDLE cycle with `gnt`=0 before the next grant. The minimum spacing between grants is 2 cycles, so there are no back-to-back handovers.
- **Maximum hold:** `gnt` is high for exactly MAX_HOLD cycles when the owner never drops its request.
- **Revocation timing:** `timeout` is high in the same cycle that `gnt` first reads 0. The revoked requester's `mask` bit is visible to the arbitration in that same IDLE cycle.
- **MAX_HOLD=1:** every grant lasts exactly 1 cycle. If the owner still requests, `timeout` fires after every grant.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `req`=4'b1111 → `gnt`=0000, `gnt_valid`=0, `timeout`=0 throughout. On the first edge after reset release, `gnt`=0001 and `gnt_id`=00.
- **Priority:** `req`=4'b0110 held, then requester 1 drops after 3 grant cycles → `gnt`=0010, `gnt_id`=01 for 3 cycles; one idle cycle with `gnt`=0000; then `gnt`=0100, `gnt_id`=10.
- **Timeout (MAX_HOLD=4):** `req`=4'b1000 held → `gnt`=1000 for 4 cycles, then `gnt`=0000 with a one-cycle `timeout` pulse. No further grant until `req[3]` drops for one cycle and reasserts, after which `gnt`=1000 again 1 cycle later.
- **Masking fairness (MAX_HOLD=4):** `req`=4'b0011 held → requester 0 is granted for 4 cycles and times out; next grant is `gnt`=0010 for 4 cycles with a timeout; then IDLE with mask=0011 while `req` stays high.
- **No preemption:** `req`=4'b0100 is granted, then `req[0]` rises mid-grant → `gnt` stays at 0100 until `req[2]` drops; after one idle cycle, `gnt`=0001.
- **Reset mid-grant:** during a grant with mask=0010 set, pulse `rst` → all outputs are 0 and mask=0, with no `timeout` pulse. Arbitration restarts from `req` on the next edge.

Source files
------------

// File: rtl/lp_arbiter.sv
// Four-requester fixed-priority arbiter with hold limit.
// Revoked owners stay masked until they drop their request.
module lp_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] mask_q, mask_d, mask_set;
  logic [3:0] elig, gnt_d;
  logic [1:0] win, id_d;
  logic       win_vld, valid_d, to_d;

  assign elig = req & ~mask_q;

  always_comb begin
    win     = 2'd0;
    win_vld = 1'b1;
    priority case (1'b1)
      elig[0]: win = 2'd0;
      elig[1]: win = 2'd1;
      elig[2]: win = 2'd2;
      elig[3]: win = 2'd3;
      default: win_vld = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    gnt_d    = gnt;
    id_d     = gnt_id;
    valid_d  = gnt_valid;
    to_d     = 1'b0;
    mask_set = 4'b0000;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win;
          id_d    = win;
          valid_d = 1'b1;
          hold_d  = 8'd1;
        end else begin
          gnt_d   = 4'b0000;
          id_d    = 2'd0;
          valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (!req[gnt_id]) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          id_d    = 2'd0;
          valid_d = 1'b0;
        end else if (hold_q == HOLD_MAX) begin
          state_d          = IDLE;
          gnt_d            = 4'b0000;
          id_d             = 2'd0;
          valid_d          = 1'b0;
          to_d             = 1'b1;
          mask_set[gnt_id] = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A dropped request clears its mask bit; a fresh revocation wins.
  assign mask_d = (mask_q & req) | mask_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hold_q    <= 8'd0;
      mask_q    <= 4'b0000;
      gnt       <= 4'b0000;
      gnt_id    <= 2'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      mask_q    <= mask_d;
      gnt       <= gnt_d;
      gnt_id    <= id_d;
      gnt_valid <= valid_d;
      timeout   <= to_d;
    end
  end

endmodule

// File: tb/tb_lp_arbiter.sv
// Directed bench for lp_arbiter: MAX_HOLD=4 main instance,
// MAX_HOLD=1 side instance sharing the same stimulus.
module tb_lp_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt, o_gnt;
  logic [1:0] gnt_id, o_gnt_id;
  logic       gnt_valid, o_gnt_valid;
  logic       timeout, o_timeout;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lp_arbiter #(.MAX_HOLD(4)) u_dut (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt), .gnt_id(gnt_id),
    .gnt_valid(gnt_valid), .timeout(timeout)
  );

  lp_arbiter #(.MAX_HOLD(1)) u_one (
    .clk(clk), .rst(rst), .req(req),
    .gnt(o_gnt), .gnt_id(o_gnt_id),
    .gnt_valid(o_gnt_valid), .timeout(o_timeout)
  );

  function automatic logic [7:0] e(input logic [3:0] g,
                                   input logic [1:0] id,
                                   input logic v,
                                   input logic t);
    return {g, id, v, t};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {gnt, gnt_id, gnt_valid, timeout};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {o_gnt, o_gnt_id, o_gnt_valid, o_timeout};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b1111;
    step(); chk("rst0", e(4'b0000, 2'd0, 1'b0, 1'b0));
    step(); chk("rst1", e(4'b0000, 2'd0, 1'b0, 1'b0));
    chk1("rst1_h1", e(4'b0000, 2'd0, 1'b0, 1'b0));
    rst = 1'b0;

    // first edge after reset; hold-1 instance times out every grant
    step(); chk("post_rst", e(4'b0001, 2'd0, 1'b1, 1'b0));
    chk1("h1_g0", e(4'b0001, 2'd0, 1'b1, 1'b0));
    step(); chk("hold2", e(4'b0001, 2'd0, 1'b1, 1'b0));
    chk1("h1_to0", e(4'b0000, 2'd0, 1'b0, 1'b1));
    step(); chk("hold3", e(4'b0001, 2'd0, 1'b1, 1'b0));
    chk1("h1_g1", e(4'b0010, 2'd1, 1'b1, 1'b0));
    step(); chk("hold4", e(4'b0001, 2'd0, 1'b1, 1'b0));
    chk1("h1_to1", e(4'b0000, 2'd0, 1'b0, 1'b1));
    step(); chk("rev0", e(4'b0000, 2'd0, 1'b0, 1'b1));
    chk1("h1_g2", e(4'b0100, 2'd2, 1'b1, 1'b0));
    req = 4'b0000;
    step(); chk("idle0", e(4'b0000, 2'd0, 1'b0, 1'b0));
    chk1("h1_rel", e(4'b0000, 2'd0, 1'b0, 1'b0));

    // priority: 1 beats 2, released after 3 cycles
    req = 4'b0110;
    step(); chk("pri_g1a", e(4'b0010, 2'd1, 1'b1, 1'b0));
    step(); chk("pri_g1b", e(4'b0010, 2'd1, 1'b1, 1'b0));
    step(); chk("pri_g1c", e(4'b0010, 2'd1, 1'b1, 1'b0));
    req = 4'b0100;
    step(); chk("pri_gap", e(4'b0000, 2'd0, 1'b0, 1'b0));
    step(); chk("pri_g2", e(4'b0100, 2'd2, 1'b1, 1'b0));

    // no preemption by req[0]
    req = 4'b0101;
    step(); chk("npre_a", e(4'b0100, 2'd2, 1'b1, 1'b0));
    step(); chk("npre_b", e(4'b0100, 2'd2, 1'b1, 1'b0));
    req = 4'b0001;
    step(); chk("npre_gap", e(4'b0000, 2'd0, 1'b0, 1'b0));
    step(); chk("npre_g0", e(4'b0001, 2'd0, 1'b1, 1'b0));
    req = 4'b0000;
    step(); chk("idle1", e(4'b0000, 2'd0, 1'b0, 1'b0));

    // timeout and parking of requester 3
    req = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      step(); chk("to_g3", e(4'b1000, 2'd3, 1'b1, 1'b0));
    end
    step(); chk("to_pulse", e(4'b0000, 2'd0, 1'b0, 1'b1));
    step(); chk("to_park0", e(4'b0000, 2'd0, 1'b0, 1'b0));
    step(); chk("to_park1", e(4'b0000, 2'd0, 1'b0, 1'b0));
    req = 4'b0000;
    step(); chk("to_drop", e(4'b0000, 2'd0, 1'b0, 1'b0));
    req = 4'b1000;
    step(); chk("to_regnt", e(4'b1000, 2'd3, 1'b1, 1'b0));
    req = 4'b0000;
    step(); chk("idle2", e(4'b0000, 2'd0, 1'b0, 1'b0));

    // masking fairness
    req = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      step(); chk("mf_g0", e(4'b0001, 2'd0, 1'b1, 1'b0));
    end
    step(); chk("mf_to0", e(4'b0000, 2'd0, 1'b0, 1'b1));
    for (int i = 0; i < 4; i++) begin
      step(); chk("mf_g1", e(4'b0010, 2'd1, 1'b1, 1'b0));
    end
    step(); chk("mf_to1", e(4'b0000, 2'd0, 1'b0, 1'b1));
    step(); chk("mf_park0", e(4'b0000, 2'd0, 1'b0, 1'b0));
    step(); chk("mf_park1", e(4'b0000, 2'd0, 1'b0, 1'b0));

    // reset mid-grant with mask[1] still set
    req = 4'b0110;
    step(); chk("rm_g2", e(4'b0100, 2'd2, 1'b1, 1'b0));
    step(); chk("rm_g2b", e(4'b0100, 2'd2, 1'b1, 1'b0));
    rst = 1'b1;
    step(); chk("rm_rst", e(4'b0000, 2'd0, 1'b0, 1'b0));
    rst = 1'b0;
    step(); chk("rm_g1", e(4'b0010, 2'd1, 1'b1, 1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
